// File: rtl/jtag_scan_sequencer.sv
// Command-driven JTAG master: walks the TAP through reset, IR and DR scans
// from a shadow copy of the TAP state, with TMS/TDI registered.
module jtag_scan_sequencer #(
   parameter int MAX_LEN = 32,
   parameter int LW      = $clog2(MAX_LEN+1)
) (
   input  logic               TCK,
   input  logic               TRSTn,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LW-1:0]      cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               TMS,
   output logic               TDI,
   input  logic               TDO,
   output logic               rsp_valid,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               busy
);

   typedef enum logic [2:0] {
      S_RST_WALK, S_IDLE, S_SEL_DR, S_SEL_IR, S_CAPTURE, S_SHIFT, S_EXIT1, S_UPDATE
   } state_t;

   state_t             r_state;
   logic [2:0]         r_walk;
   logic               r_pend;
   logic               r_ir;
   logic               r_rst_op;
   logic [LW-1:0]      r_len;
   logic [LW-1:0]      r_idx;
   logic [MAX_LEN-1:0] r_data;
   logic [MAX_LEN-1:0] r_rsp;
   logic               r_tms;
   logic               r_tdi;
   logic               r_ready;
   logic               r_rsp_vld;

   logic [LW-1:0]      w_len_clamp;
   logic               w_last;
   logic [MAX_LEN-1:0] w_tdo_bit;

   assign w_len_clamp = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
   assign w_last      = (r_idx == r_len - LW'(1));
   assign w_tdo_bit   = {{(MAX_LEN-1){1'b0}}, TDO} << r_idx;

   always_ff @(posedge TCK or negedge TRSTn) begin
      if (!TRSTn) begin
         r_state   <= S_RST_WALK;
         r_walk    <= '0;
         r_pend    <= 1'b0;
         r_ir      <= 1'b0;
         r_rst_op  <= 1'b0;
         r_len     <= '0;
         r_idx     <= '0;
         r_data    <= '0;
         r_rsp     <= '0;
         r_tms     <= 1'b1;
         r_tdi     <= 1'b0;
         r_ready   <= 1'b0;
         r_rsp_vld <= 1'b0;
      end else begin
         r_rsp_vld <= 1'b0;
         case (r_state)
            // Five TMS=1 edges reach Test_Logic_Reset from anywhere, the sixth (TMS=0) lands in Run_Test_Idle.
            S_RST_WALK: begin
               if (r_walk == 3'd5) begin
                  r_state   <= S_IDLE;
                  r_walk    <= '0;
                  r_tms     <= 1'b0;
                  r_ready   <= 1'b1;
                  r_rsp_vld <= r_rst_op;
                  r_rst_op  <= 1'b0;
               end else begin
                  r_walk <= r_walk + 3'd1;
                  r_tms  <= (r_walk < 3'd4);
               end
            end
            S_IDLE: begin
               if (r_pend) begin
                  r_pend <= 1'b0;
                  if (r_len == '0) begin
                     r_rsp_vld <= 1'b1;
                     r_ready   <= 1'b1;
                  end else begin
                     r_state <= S_SEL_DR;
                     r_tms   <= r_ir;
                  end
               end else if (cmd_valid && r_ready) begin
                  r_ready <= 1'b0;
                  r_rsp   <= '0;
                  r_data  <= cmd_data;
                  r_ir    <= (cmd_op == 2'd1);
                  r_len   <= w_len_clamp;
                  r_idx   <= '0;
                  if (cmd_op == 2'd2) begin
                     r_state  <= S_RST_WALK;
                     r_walk   <= '0;
                     r_tms    <= 1'b1;
                     r_rst_op <= 1'b1;
                  end else begin
                     // TAP is still in Run_Test_Idle after this edge; the move starts next edge.
                     r_pend <= 1'b1;
                     r_tms  <= (w_len_clamp != '0);
                  end
               end
            end
            S_SEL_DR: begin
               r_state <= r_ir ? S_SEL_IR : S_CAPTURE;
               r_tms   <= 1'b0;
            end
            S_SEL_IR: begin
               r_state <= S_CAPTURE;
               r_tms   <= 1'b0;
            end
            S_CAPTURE: begin
               r_state <= S_SHIFT;
               r_tdi   <= r_data[0];
               r_tms   <= (r_len == LW'(1));
            end
            S_SHIFT: begin
               r_rsp <= r_rsp | w_tdo_bit;
               if (w_last) begin
                  r_state <= S_EXIT1;
                  r_tdi   <= 1'b0;
                  r_tms   <= 1'b1;
               end else begin
                  r_idx  <= r_idx + LW'(1);
                  r_data <= r_data >> 1;
                  r_tdi  <= r_data[1];
                  r_tms  <= (r_idx + LW'(2) == r_len);
               end
            end
            S_EXIT1: begin
               r_state <= S_UPDATE;
               r_tms   <= 1'b0;
            end
            S_UPDATE: begin
               r_state   <= S_IDLE;
               r_tms     <= 1'b0;
               r_ready   <= 1'b1;
               r_rsp_vld <= 1'b1;
            end
            default: begin
               r_state <= S_RST_WALK;
               r_walk  <= '0;
               r_tms   <= 1'b1;
            end
         endcase
      end
   end

   assign TMS       = r_tms;
   assign TDI       = r_tdi;
   assign cmd_ready = r_ready;
   assign busy      = ~r_ready;
   assign rsp_valid = r_rsp_vld;
   assign rsp_data  = r_rsp;

endmodule
